fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), the bubble instruction.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port PCSrcE  input  1  branch/jump taken in Execute.
REQ-006 SHALL have port PCTargetE  input  32  redirect target from Execute.
REQ-007 SHALL have port StallF  input  1  hold the PC (load-use stall).
REQ-008 SHALL have port StallD  input  1  hold the IF/ID register.
REQ-009 SHALL have port FlushD  input  1  replace the IF/ID contents with a bubble.
REQ-010 SHALL have port imem_req  output  1  fetch request, held until imem_valid.
REQ-011 SHALL have port imem_addr  output  32  fetch address, stable while imem_req=1.
REQ-012 SHALL have port imem_rdata  input  32  returned instruction word.
REQ-013 SHALL have port imem_valid  input  1  imem_rdata valid for the current request; may be asserted in the cycle of the request.
REQ-014 SHALL have outputs InstrD (32), PCD (32), PCPlus4D (32) and ValidD (1): the IF/ID register contents.
REQ-015 SHALL have port FetchBusy  output  1  high when no instruction can be delivered this cycle.

Function
REQ-016 SHALL implement the FSM states BOOT, FETCH and DISCARD; BOOT goes to FETCH after one cycle.
REQ-017 In BOOT: imem_req=0; D is written with a bubble.
REQ-018 In FETCH: imem_req=1 and imem_addr=PCF.
REQ-019 On accept (FETCH, imem_valid=1, StallF=0, PCSrcE=0): PCF<=PCF+4; D<={imem_rdata, PCF, PCF+4, ValidD=1} unless StallD or FlushD.
REQ-020 In FETCH with imem_valid=1 and StallF=1: data SHALL be dropped, PCF held, and the same address re-requested next cycle.
REQ-021 In FETCH with imem_valid=0: FetchBusy=1; D gets a bubble unless StallD=1.
REQ-022 PCSrcE=1 SHALL override StallF and load PCF<=PCTargetE.
REQ-023 If PCSrcE=1 while a request is pending (FETCH, imem_valid=0): the old address SHALL be latched in ReqAddr and the FSM SHALL go to DISCARD.
REQ-024 In DISCARD: imem_req=1 and imem_addr=ReqAddr; on imem_valid the data SHALL be dropped and the FSM SHALL go to FETCH; FetchBusy=1; D gets a bubble.
REQ-025 A further PCSrcE while in DISCARD SHALL update only PCF.
REQ-026 D-register priority SHALL be FlushD > StallD > load; a bubble is InstrD=NOP_INSTR, ValidD=0, with PCD and PCPlus4D zeroed.
REQ-027 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-028 PCTargetE[1:0] SHALL be forced to 2'b00 when loaded.
REQ-029 At most one request SHALL be outstanding; responses are in order.

Reset
REQ-030 While rst=0 at a clock edge: PCF=RESET_PC, FSM=BOOT, ReqAddr=0, D=bubble, and imem_req=0 the following cycle.
REQ-031 Reset asserted mid-request (FETCH or DISCARD) SHALL abandon the request; a late imem_valid in BOOT SHALL be ignored.
REQ-032 During reset and BOOT: FetchBusy=1.

Structure
REQ-033 The FSM state encoding, RESET_PC and NOP_INSTR SHALL live in the shared core package (rv32i_pkg).
REQ-034 The IF/ID register SHALL be a sub-module if_id_reg (stall/flush/load, with the priority of REQ-026); PCF, the FSM and ReqAddr SHALL stay in fetch_stage.

Verification
REQ-035 Zero-latency memory, no stalls, after reset: imem_addr sequence 0,4,8,C; InstrD follows one cycle later with ValidD=1.
REQ-036 StallF=StallD=1 for one cycle at PCF=8: PCF stays 8, D holds, address 8 is re-requested, no instruction is lost or duplicated.
REQ-037 PCSrcE=1, PCTargetE=32'h100, with a 3-cycle memory latency in progress at PCF=C: the FSM enters DISCARD, the word for C is dropped, the next fetch is at 0x100, and ValidD=0 until the 0x100 word arrives.
REQ-038 FlushD=1 and StallD=1 together: D becomes a bubble (InstrD=32'h13, ValidD=0).
REQ-039 rst=0 asserted mid-DISCARD, then a late imem_valid arrives: it is ignored, and the first fetch after BOOT is at RESET_PC.
REQ-040 PCSrcE to 32'hFFFF_FFFC, then one accept: the next imem_addr is 32'h0000_0000.

Source files
------------

// File: rtl/rv32i_pkg.sv
// ============================================================================
// Module  : rv32i_pkg
// Brief   : Shared core types and constants: fetch FSM states and IF/ID record.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_pkg;

  localparam logic [31:0] c_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_BOOT    = 2'd0,
    FS_FETCH   = 2'd1,
    FS_DISCARD = 2'd2
  } fetchState_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        valid;
  } ifId_t;

  function automatic ifId_t bubble(input logic [31:0] nop);
    ifId_t b;
    b.instr   = nop;
    b.pc      = '0;
    b.pcPlus4 = '0;
    b.valid   = 1'b0;
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// Module  : if_id_reg
// Brief   : IF/ID pipeline register with flush > stall > load priority.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_reg
  import rv32i_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = c_NOP_INSTR
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_stall,
  input  logic  i_flush,
  input  ifId_t i_ifId,
  output ifId_t o_ifId
);

  ifId_t r_ifId;

  always_ff @(posedge clk) begin
    if (!rst || i_flush) begin
      r_ifId <= bubble(NOP_INSTR);
    end else if (!i_stall) begin
      r_ifId <= i_ifId;
    end
  end

  assign o_ifId = r_ifId;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module  : fetch_stage
// Brief   : Instruction fetch: PC, single-outstanding imem handshake, IF/ID reg.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = c_RESET_PC,
  parameter logic [31:0] NOP_INSTR = c_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        FetchBusy
);

  fetchState_e r_state;
  logic [31:0] r_pcF;
  logic [31:0] r_reqAddr;

  logic [31:0] w_pcPlus4F;
  logic [31:0] w_target;
  logic        w_accept;
  ifId_t       w_ifIdNext;
  ifId_t       w_ifIdQ;

  assign w_pcPlus4F = r_pcF + 32'd4;
  assign w_target   = PCTargetE & ~32'h0000_0003;
  assign w_accept   = (r_state == FS_FETCH) && imem_valid && !StallF && !PCSrcE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= FS_BOOT;
      r_pcF     <= RESET_PC;
      r_reqAddr <= '0;
    end else begin
      if (PCSrcE) begin
        r_pcF <= w_target;
      end else if (w_accept) begin
        r_pcF <= w_pcPlus4F;
      end
      case (r_state)
        FS_BOOT: r_state <= FS_FETCH;
        FS_FETCH: begin
          // A redirect cannot cancel an issued request; remember it so the
          // stale response can be swallowed while the address stays stable.
          if (PCSrcE && !imem_valid) begin
            r_reqAddr <= r_pcF;
            r_state   <= FS_DISCARD;
          end
        end
        FS_DISCARD: begin
          if (imem_valid) begin
            r_state <= FS_FETCH;
          end
        end
        default: r_state <= FS_BOOT;
      endcase
    end
  end

  assign imem_req  = (r_state == FS_FETCH) || (r_state == FS_DISCARD);
  assign imem_addr = (r_state == FS_DISCARD) ? r_reqAddr : r_pcF;
  assign FetchBusy = !rst || (r_state != FS_FETCH) || !imem_valid;

  always_comb begin
    w_ifIdNext = bubble(NOP_INSTR);
    if (w_accept) begin
      w_ifIdNext.instr   = imem_rdata;
      w_ifIdNext.pc      = r_pcF;
      w_ifIdNext.pcPlus4 = w_pcPlus4F;
      w_ifIdNext.valid   = 1'b1;
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_ifIdReg (
    .clk    (clk),
    .rst    (rst),
    .i_stall(StallD),
    .i_flush(FlushD),
    .i_ifId (w_ifIdNext),
    .o_ifId (w_ifIdQ)
  );

  assign InstrD   = w_ifIdQ.instr;
  assign PCD      = w_ifIdQ.pc;
  assign PCPlus4D = w_ifIdQ.pcPlus4;
  assign ValidD   = w_ifIdQ.valid;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module  : tb_fetch_stage
// Brief   : Directed vector table plus randomized latency/stall/redirect run.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic        FetchBusy;

  fetch_stage dut (
    .clk       (clk),
    .rst       (rst),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .imem_valid(imem_valid),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD),
    .FetchBusy (FetchBusy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'hA000_0003 ^ (a << 4);
  endfunction

  typedef struct {
    logic        rstN;
    logic        pcSrc;
    logic [31:0] target;
    logic        stF;
    logic        stD;
    logic        fl;
    logic        vld;
    logic [31:0] rdata;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expBusy;
    logic [31:0] dAddr;
    logic        dValid;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rstN, input logic pcSrc, input logic [31:0] target,
                     input logic stF, input logic stD, input logic fl, input logic vld,
                     input logic [31:0] rdata, input logic eReq, input logic [31:0] eAddr,
                     input logic eBusy, input logic [31:0] dAddr, input logic dValid);
    vec_t v;
    v.rstN = rstN; v.pcSrc = pcSrc; v.target = target;
    v.stF = stF; v.stD = stD; v.fl = fl; v.vld = vld; v.rdata = rdata;
    v.expReq = eReq; v.expAddr = eAddr; v.expBusy = eBusy;
    v.dAddr = dAddr; v.dValid = dValid;
    vecs.push_back(v);
  endtask

  task automatic idleInputs();
    PCSrcE = 1'b0; PCTargetE = '0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    imem_valid = 1'b0; imem_rdata = '0;
  endtask

  // Random-phase model state
  logic [31:0] nextPc;
  logic        pending;
  logic [31:0] pAddr;
  int          waitCnt;
  int          deliveries;
  logic [31:0] mInstr, mPc, mPc4;
  logic        mValid;
  logic        deliver;

  initial begin
    rst = 1'b0;
    idleInputs();
    repeat (2) @(posedge clk);
    #1;

    // rstN pcSrc target  stF stD fl vld rdata  | req addr busy | D addr valid
    add(0, 0, 32'h0,   0, 0, 0, 0, 32'h0,             0, 32'h0, 1,   32'h0, 0);
    add(1, 0, 32'h0,   0, 0, 0, 0, 32'h0,             0, 32'h0, 1,   32'h0, 0);
    add(1, 0, 32'h0,   0, 0, 0, 1, memWord(32'h0),    1, 32'h0, 0,   32'h0, 1);
    add(1, 0, 32'h0,   0, 0, 0, 1, memWord(32'h4),    1, 32'h4, 0,   32'h4, 1);
    add(1, 0, 32'h0,   1, 1, 0, 1, memWord(32'h8),    1, 32'h8, 0,   32'h4, 1);
    add(1, 0, 32'h0,   0, 0, 0, 1, memWord(32'h8),    1, 32'h8, 0,   32'h8, 1);
    add(1, 0, 32'h0,   0, 0, 0, 0, 32'h0,             1, 32'hC, 1,   32'h0, 0);
    add(1, 0, 32'h0,   0, 0, 0, 0, 32'h0,             1, 32'hC, 1,   32'h0, 0);
    add(1, 1, 32'h100, 0, 0, 1, 0, 32'h0,             1, 32'hC, 1,   32'h0, 0);
    add(1, 0, 32'h0,   0, 0, 0, 1, memWord(32'hC),    1, 32'hC, 1,   32'h0, 0);
    add(1, 0, 32'h0,   0, 0, 0, 1, memWord(32'h100),  1, 32'h100, 0, 32'h100, 1);
    add(1, 0, 32'h0,   0, 1, 1, 1, memWord(32'h104),  1, 32'h104, 0, 32'h0, 0);
    add(1, 1, 32'hFFFF_FFFE, 0, 0, 1, 1, memWord(32'h108), 1, 32'h108, 0, 32'h0, 0);
    add(1, 0, 32'h0,   0, 0, 0, 1, memWord(32'hFFFF_FFFC), 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1);
    add(1, 1, 32'h40,  0, 0, 1, 1, memWord(32'h0),    1, 32'h0, 0,   32'h0, 0);
    add(1, 0, 32'h0,   0, 0, 0, 0, 32'h0,             1, 32'h40, 1,  32'h0, 0);
    add(1, 1, 32'h200, 0, 0, 1, 0, 32'h0,             1, 32'h40, 1,  32'h0, 0);
    add(1, 1, 32'h300, 0, 0, 1, 0, 32'h0,             1, 32'h40, 1,  32'h0, 0);
    add(0, 0, 32'h0,   0, 0, 0, 0, 32'h0,             1, 32'h40, 1,  32'h0, 0);
    add(1, 0, 32'h0,   0, 0, 0, 1, memWord(32'h40),   0, 32'h0, 1,   32'h0, 0);
    add(1, 0, 32'h0,   0, 0, 0, 1, memWord(32'h0),    1, 32'h0, 0,   32'h0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rstN; PCSrcE = vecs[i].pcSrc; PCTargetE = vecs[i].target;
      StallF = vecs[i].stF; StallD = vecs[i].stD; FlushD = vecs[i].fl;
      imem_valid = vecs[i].vld; imem_rdata = vecs[i].rdata;
      @(negedge clk);
      check($sformatf("row%0d imem_req", i), 32'(imem_req), 32'(vecs[i].expReq));
      check($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].expAddr);
      check($sformatf("row%0d FetchBusy", i), 32'(FetchBusy), 32'(vecs[i].expBusy));
      @(posedge clk);
      #1;
      check($sformatf("row%0d InstrD", i), InstrD, vecs[i].dValid ? memWord(vecs[i].dAddr) : NOP);
      check($sformatf("row%0d PCD", i), PCD, vecs[i].dValid ? vecs[i].dAddr : 32'h0);
      check($sformatf("row%0d PCPlus4D", i), PCPlus4D, vecs[i].dValid ? vecs[i].dAddr + 32'd4 : 32'h0);
      check($sformatf("row%0d ValidD", i), 32'(ValidD), 32'(vecs[i].dValid));
    end

    // Randomized run: memory with 0..3 cycle latency, pipeline stalls, redirects.
    idleInputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    nextPc = 32'h0; pending = 1'b0; pAddr = '0; waitCnt = 0; deliveries = 0;
    mInstr = NOP; mPc = '0; mPc4 = '0; mValid = 1'b0;

    for (int c = 0; c < 800; c++) begin
      if (imem_req) begin
        if (!pending) begin
          check("new request address", imem_addr, nextPc);
          pending = 1'b1;
          pAddr   = imem_addr;
          waitCnt = $urandom_range(0, 3);
        end else begin
          check("address stable while pending", imem_addr, pAddr);
        end
      end
      imem_valid = imem_req && pending && (waitCnt == 0);
      imem_rdata = imem_valid ? memWord(pAddr) : $urandom;
      StallF     = ($urandom_range(0, 5) == 0);
      StallD     = StallF;
      PCSrcE     = ($urandom_range(0, 11) == 0);
      PCTargetE  = $urandom;
      FlushD     = PCSrcE;
      #1;
      check("random FetchBusy", 32'(FetchBusy), 32'(!(imem_valid && pAddr == nextPc)));
      deliver = imem_valid && !StallF && !PCSrcE && (pAddr == nextPc);
      @(posedge clk);
      #1;
      if (imem_valid) pending = 1'b0;
      else if (pending && waitCnt > 0) waitCnt--;
      if (PCSrcE) begin
        nextPc = PCTargetE & ~32'h3;
        mInstr = NOP; mPc = '0; mPc4 = '0; mValid = 1'b0;
      end else if (!StallD) begin
        if (deliver) begin
          mInstr = memWord(nextPc); mPc = nextPc; mPc4 = nextPc + 32'd4; mValid = 1'b1;
          nextPc = nextPc + 32'd4;
          deliveries++;
        end else begin
          mInstr = NOP; mPc = '0; mPc4 = '0; mValid = 1'b0;
        end
      end
      check("random InstrD", InstrD, mInstr);
      check("random PCD", PCD, mPc);
      check("random PCPlus4D", PCPlus4D, mPc4);
      check("random ValidD", 32'(ValidD), 32'(mValid));
    end
    check("random deliveries above 50", 32'(deliveries > 50), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
